sensor_bcd_sequencer: RTL

Time-multiplexed BCD-to-binary conversion controller for the eight sensor readout channels (heart rate, H2, liquefied gas, natural gas, harmful gas, oxygen, temperature, humidity).
- Replaces per-channel multipliers with one shared multiply-accumulate step, sequenced channel by channel.
- Sits between the digit-extraction logic and the display/alarm logic.
- Each sweep is triggered by a start pulse. Per-channel 8-bit binary results, saturation flags and BCD-error flags are held in registers until the next sweep overwrites them.

---
 rtl/sensor_pkg.sv | 29 ++
 rtl/bcd_mac_step.sv | 23 ++
 rtl/sensor_bcd_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor BCD-to-binary sequencer.
// Holds the channel count, digit and result widths, the sequencer
// state encoding, the channel index map and the saturation ceiling.
package sensor_pkg;

    localparam int N_CH     = 8;    // sensor readout channels
    localparam int DIGIT_W  = 4;    // one BCD digit
    localparam int OUT_W    = 8;    // binary result per channel
    localparam int ACC_W    = 10;   // holds up to 999 without overflow
    localparam int CH_DIG_W = 3 * DIGIT_W;  // {hun, ten, one} per channel
    localparam int SAT_MAX  = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2
    } state_t;

    // Channel order as presented by the digit-extraction logic.
    localparam int CH_HEART   = 0;
    localparam int CH_H2      = 1;
    localparam int CH_LIQ_GAS = 2;
    localparam int CH_NAT_GAS = 3;
    localparam int CH_HARMFUL = 4;
    localparam int CH_OXYGEN  = 5;
    localparam int CH_TEMP    = 6;
    localparam int CH_HUM     = 7;

endpackage

// File: rtl/bcd_mac_step.sv
// One multiply-accumulate step of a BCD-to-binary conversion.
// Purely combinational; shared by all channels through the sequencer.
//   acc_i   : running binary accumulator
//   digit_i : next BCD digit, most significant first
//   acc_o   : acc_i*10 + digit_i (times ten built from two shifts)
//   bad_o   : digit_i is not a legal BCD digit
module bcd_mac_step
    import sensor_pkg::*;
(
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [ACC_W-1:0]   acc_o,
    output logic               bad_o
);

    always_comb begin
        acc_o = {acc_i[ACC_W-4:0], 3'b000}
              + {acc_i[ACC_W-2:0], 1'b0}
              + {{(ACC_W-DIGIT_W){1'b0}}, digit_i};
        bad_o = (digit_i > DIGIT_W'(9));
    end

endmodule

// File: rtl/sensor_bcd_sequencer.sv
// Time-multiplexed BCD-to-binary converter for the sensor channels.
// A start pulse snapshots the digits and channel mask, then each enabled
// channel is converted in turn (3 MAC cycles + 1 STORE cycle) through a
// single shared bcd_mac_step. Results stay registered until rewritten.
//   clk, rst : system clock, synchronous active-high reset
//   start    : one-cycle sweep request, honoured only in IDLE
//   en_mask  : per-channel enable, sampled with start
//   digits   : {hun, ten, one} BCD per channel, 12 bits per channel
//   value    : clamped 8-bit binary result per channel
//   sat      : result was above 255 and clamped
//   err      : last conversion saw a digit above 9 (value/sat held)
//   upd      : one-cycle strobe when a channel's registers are written
//   busy     : sweep in progress
//   done     : one-cycle pulse at sweep completion
module sensor_bcd_sequencer #(
    parameter int N_CH  = sensor_pkg::N_CH,
    parameter int OUT_W = sensor_pkg::OUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_CH-1:0]       en_mask,
    input  logic [12*N_CH-1:0]    digits,
    output logic [OUT_W*N_CH-1:0] value,
    output logic [N_CH-1:0]       sat,
    output logic [N_CH-1:0]       err,
    output logic [N_CH-1:0]       upd,
    output logic                  busy,
    output logic                  done
);
    import sensor_pkg::*;

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t              state_reg, state_next;
    logic [12*N_CH-1:0]  digits_reg;
    logic [N_CH-1:0]     mask_reg;
    logic [CH_W-1:0]     ch_ptr_reg;
    logic [1:0]          step_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic                bad_reg;
    logic                empty_reg;   // empty-mask request: done follows one cycle later
    logic                done_reg;

    logic [OUT_W-1:0]    value_reg [N_CH];
    logic                sat_reg   [N_CH];
    logic                err_reg   [N_CH];
    logic                upd_reg   [N_CH];

    logic [CH_DIG_W-1:0] ch_word [N_CH];
    logic [CH_DIG_W-1:0] cur_word;
    logic [DIGIT_W-1:0]  cur_digit;
    logic [ACC_W-1:0]    mac_acc;
    logic                mac_bad;

    logic                start_found, next_found;
    logic [CH_W-1:0]     start_idx, next_idx;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_word
            assign ch_word[gi] = digits_reg[CH_DIG_W*gi +: CH_DIG_W];
        end
    endgenerate

    // Digit order within a channel word is hundreds first.
    always_comb begin
        cur_word = ch_word[ch_ptr_reg];
        case (step_reg)
            2'd0:    cur_digit = cur_word[11:8];
            2'd1:    cur_digit = cur_word[7:4];
            default: cur_digit = cur_word[3:0];
        endcase
    end

    bcd_mac_step u_mac (
        .acc_i   (acc_reg),
        .digit_i (cur_digit),
        .acc_o   (mac_acc),
        .bad_o   (mac_bad)
    );

    // Priority scans: lowest enabled channel of the live mask (sweep start)
    // and lowest snapshot channel strictly above the current pointer.
    always_comb begin
        start_found = 1'b0;
        start_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                start_found = 1'b1;
                start_idx   = CH_W'(i);
            end
            if (mask_reg[i] && (i > int'(ch_ptr_reg))) begin
                next_found = 1'b1;
                next_idx   = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && start_found) state_next = MAC;
            MAC:     if (step_reg == 2'd2)     state_next = STORE;
            STORE:   state_next = next_found ? MAC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_reg <= '0;
            mask_reg   <= '0;
            ch_ptr_reg <= '0;
            step_reg   <= '0;
            acc_reg    <= '0;
            bad_reg    <= 1'b0;
            empty_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            empty_reg <= 1'b0;
            done_reg  <= empty_reg;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        digits_reg <= digits;
                        mask_reg   <= en_mask;
                        ch_ptr_reg <= start_idx;
                        step_reg   <= '0;
                        acc_reg    <= '0;
                        bad_reg    <= 1'b0;
                        empty_reg  <= !start_found;
                    end
                end
                MAC: begin
                    acc_reg  <= mac_acc;
                    bad_reg  <= bad_reg | mac_bad;
                    step_reg <= step_reg + 2'd1;
                end
                STORE: begin
                    if (next_found) begin
                        ch_ptr_reg <= next_idx;
                        step_reg   <= '0;
                        acc_reg    <= '0;
                        bad_reg    <= 1'b0;
                    end else begin
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-channel result registers; only the channel under STORE is written.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic store_hit;
            assign store_hit = (state_reg == STORE) && (ch_ptr_reg == CH_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    value_reg[gi] <= '0;
                    sat_reg[gi]   <= 1'b0;
                    err_reg[gi]   <= 1'b0;
                    upd_reg[gi]   <= 1'b0;
                end else begin
                    upd_reg[gi] <= store_hit;
                    if (store_hit) begin
                        if (bad_reg) begin
                            err_reg[gi] <= 1'b1;
                        end else begin
                            err_reg[gi] <= 1'b0;
                            if (acc_reg > ACC_W'(SAT_MAX)) begin
                                value_reg[gi] <= OUT_W'(SAT_MAX);
                                sat_reg[gi]   <= 1'b1;
                            end else begin
                                value_reg[gi] <= acc_reg[OUT_W-1:0];
                                sat_reg[gi]   <= 1'b0;
                            end
                        end
                    end
                end
            end

            assign value[OUT_W*gi +: OUT_W] = value_reg[gi];
            assign sat[gi] = sat_reg[gi];
            assign err[gi] = err_reg[gi];
            assign upd[gi] = upd_reg[gi];
        end
    endgenerate

    assign busy = (state_reg != IDLE);
    assign done = done_reg;

endmodule
